// File: rtl/ula_sequenciador.sv
// Sequencing controller for the ULA datapath: single-cycle ops, iterative MUL and DIV,
// with registered result/flags. Optional `resto` output is enabled by macro ULA_RESTO_EN.
module ula_sequenciador #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    input  logic               Cin,
    output logic               busy,
    output logic               done,
    output logic [LARGURA-1:0] result,
    output logic               overflow,
    output logic               zero
`ifdef ULA_RESTO_EN
    ,
    output logic [LARGURA-1:0] resto
`endif
);

    localparam int CW = $clog2(LARGURA + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_FIM
    } estado_t;

    estado_t                r_state;
    logic [2:0]             r_op;
    logic [LARGURA-1:0]     r_a;
    logic [LARGURA-1:0]     r_b;
    logic                   r_cin;
    logic [2*LARGURA-1:0]   r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [LARGURA-1:0]     r_result;
    logic                   r_overflow;
    logic                   r_zero;

    logic [LARGURA:0]       w_soma;
    logic [LARGURA:0]       w_dif;
    logic [LARGURA-1:0]     w_exec_res;
    logic                   w_exec_ov;
    logic [LARGURA:0]       w_mul_sum;
    logic [2*LARGURA-1:0]   w_mul_next;
    logic [LARGURA:0]       w_div_sh;
    logic [LARGURA:0]       w_div_dif;
    logic                   w_div_ge;
    logic [LARGURA-1:0]     w_div_rem;
    logic [2*LARGURA-1:0]   w_div_next;
    logic                   w_ultimo;

    assign w_soma = {1'b0, r_a} + {1'b0, r_b} + {{LARGURA{1'b0}}, r_cin};
    // Bit LARGURA of the 9-bit difference is the borrow (A < B + Cin).
    assign w_dif  = {1'b0, r_a} - {1'b0, r_b} - {{LARGURA{1'b0}}, r_cin};

    always_comb begin
        w_exec_res = '0;
        w_exec_ov  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_exec_res = w_soma[LARGURA-1:0];
                w_exec_ov  = w_soma[LARGURA];
            end
            OP_SUB: begin
                w_exec_res = w_dif[LARGURA-1:0];
                w_exec_ov  = w_dif[LARGURA];
            end
            OP_OR:  w_exec_res = r_a | r_b;
            OP_AND: w_exec_res = r_a & r_b;
            OP_XOR: w_exec_res = r_a ^ r_b;
            OP_DIV: begin
                w_exec_res = '1;
                w_exec_ov  = 1'b1;
            end
            OP_NOT: w_exec_res = ~r_a;
            default: w_exec_res = '0;
        endcase
    end

    // Shift-add: accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*LARGURA-1:LARGURA]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[LARGURA-1:1]};

    // Restoring division: accumulator holds {remainder, dividend/quotient}. The remainder
    // stays below B, so the shifted value is under 2B and the sign of the trial subtraction
    // alone decides the quotient bit.
    assign w_div_sh   = {r_acc[2*LARGURA-1:LARGURA], r_acc[LARGURA-1]};
    assign w_div_dif  = w_div_sh - {1'b0, r_b};
    assign w_div_ge   = ~w_div_dif[LARGURA];
    assign w_div_rem  = w_div_ge ? w_div_dif[LARGURA-1:0] : w_div_sh[LARGURA-1:0];
    assign w_div_next = {w_div_rem, r_acc[LARGURA-2:0], w_div_ge};

    assign w_ultimo = (r_cnt == CW'(LARGURA - 1));

`ifdef ULA_RESTO_EN
    logic [LARGURA-1:0] r_resto;
    logic [LARGURA-1:0] w_exec_resto;

    assign w_exec_resto = (r_op == OP_DIV) ? r_a : '0;
    assign resto        = r_resto;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
`ifdef ULA_RESTO_EN
            r_resto    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_a    <= A;
                        r_b    <= B;
                        r_cin  <= Cin;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        r_acc  <= (op == OP_MUL) ? {{LARGURA{1'b0}}, B} : {{LARGURA{1'b0}}, A};
                        if (op == OP_MUL)
                            r_state <= S_MUL;
                        else if (op == OP_DIV && B != '0)
                            r_state <= S_DIV;
                        else
                            r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result   <= w_exec_res;
                    r_overflow <= w_exec_ov;
                    r_zero     <= (w_exec_res == '0);
`ifdef ULA_RESTO_EN
                    r_resto    <= w_exec_resto;
`endif
                    r_done     <= 1'b1;
                    r_state    <= S_FIM;
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ultimo) begin
                        r_result   <= w_mul_next[LARGURA-1:0];
                        r_overflow <= (w_mul_next[2*LARGURA-1:LARGURA] != '0);
                        r_zero     <= (w_mul_next[LARGURA-1:0] == '0);
`ifdef ULA_RESTO_EN
                        r_resto    <= w_mul_next[2*LARGURA-1:LARGURA];
`endif
                        r_done     <= 1'b1;
                        r_state    <= S_FIM;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ultimo) begin
                        r_result   <= w_div_next[LARGURA-1:0];
                        r_overflow <= 1'b0;
                        r_zero     <= (w_div_next[LARGURA-1:0] == '0);
`ifdef ULA_RESTO_EN
                        r_resto    <= w_div_next[2*LARGURA-1:LARGURA];
`endif
                        r_done     <= 1'b1;
                        r_state    <= S_FIM;
                    end
                end
                S_FIM: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed testbench for ula_sequenciador: hand-computed vectors, latency, start
// handling, and mid-operation reset abort.
module tb_ula_sequenciador;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       overflow;
    logic       zero;
`ifdef ULA_RESTO_EN
    logic [7:0] resto;
`endif

    int checks;
    int errors;

    ula_sequenciador #(.LARGURA(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
`ifdef ULA_RESTO_EN
        ,
        .resto    (resto)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and returns the number of falling edges from start until done.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic c, output int lat);
        @(negedge clk);
        op = o; A = a; B = b; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("op=%b A=%h B=%h Cin=%b -> result=%h ov=%b zero=%b lat=%0d",
                 o, a, b, c, result, overflow, zero, lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; Cin = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, result, overflow, zero} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b result=%h ov=%b zero=%b exp all 0",
                     busy, done, result, overflow, zero);
        end
    endtask

    task automatic test_add_sub;
        int lat;
        run_op(3'b000, 8'hF0, 8'h20, 1'b1, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
        checks++;
        if ({result, overflow, zero} !== {8'h11, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_result got %h/%b/%b exp 11/1/0", result, overflow, zero);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_at_done got %b exp 1", busy); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL add_after_done got busy=%b done=%b exp 0 0", busy, done);
        end
        checks++;
        if (result !== 8'h11) begin errors++; $display("FAIL add_hold got %h exp 11", result); end

        run_op(3'b001, 8'd5, 8'd5, 1'b0, lat);
        checks++;
        if ({result, overflow, zero} !== {8'h00, 1'b0, 1'b1}) begin
            errors++; $display("FAIL sub_equal got %h/%b/%b exp 00/0/1", result, overflow, zero);
        end
        run_op(3'b001, 8'd3, 8'd4, 1'b0, lat);
        checks++;
        if ({result, overflow, zero} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_borrow got %h/%b/%b exp FF/1/0", result, overflow, zero);
        end
        run_op(3'b001, 8'h10, 8'h01, 1'b1, lat);
        checks++;
        if ({result, overflow} !== {8'h0E, 1'b0}) begin
            errors++; $display("FAIL sub_cin got %h/%b exp 0E/0", result, overflow);
        end
        run_op(3'b111, 8'h3C, 8'h00, 1'b1, lat);
        checks++;
        if ({result, overflow} !== {8'hC3, 1'b0}) begin
            errors++; $display("FAIL not_result got %h/%b exp C3/0", result, overflow);
        end
        run_op(3'b010, 8'hA0, 8'h05, 1'b0, lat);
        checks++;
        if (result !== 8'hA5) begin errors++; $display("FAIL or_result got %h exp A5", result); end
        run_op(3'b011, 8'hF0, 8'h3C, 1'b0, lat);
        checks++;
        if (result !== 8'h30) begin errors++; $display("FAIL and_result got %h exp 30", result); end
`ifdef ULA_RESTO_EN
        checks++;
        if (resto !== 8'h00) begin errors++; $display("FAIL and_resto got %h exp 00", resto); end
`endif
    endtask

    task automatic test_mul;
        int lat;
        run_op(3'b101, 8'h10, 8'h10, 1'b0, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL mul_latency got %0d exp 9", lat); end
        checks++;
        if ({result, overflow, zero} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL mul_256 got %h/%b/%b exp 00/1/1", result, overflow, zero);
        end
`ifdef ULA_RESTO_EN
        checks++;
        if (resto !== 8'h01) begin errors++; $display("FAIL mul_resto got %h exp 01", resto); end
`endif
        run_op(3'b101, 8'd12, 8'd11, 1'b0, lat);
        checks++;
        if ({result, overflow, zero} !== {8'd132, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mul_132 got %h/%b/%b exp 84/0/0", result, overflow, zero);
        end
        run_op(3'b101, 8'hFF, 8'hFF, 1'b0, lat);
        checks++;
        if ({result, overflow} !== {8'h01, 1'b1}) begin
            errors++; $display("FAIL mul_ff got %h/%b exp 01/1", result, overflow);
        end
    endtask

    task automatic test_div;
        int lat;
        run_op(3'b110, 8'd200, 8'd7, 1'b0, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL div_latency got %0d exp 9", lat); end
        checks++;
        if ({result, overflow, zero} !== {8'd28, 1'b0, 1'b0}) begin
            errors++; $display("FAIL div_200_7 got %h/%b/%b exp 1c/0/0", result, overflow, zero);
        end
`ifdef ULA_RESTO_EN
        checks++;
        if (resto !== 8'd4) begin errors++; $display("FAIL div_resto got %h exp 04", resto); end
`endif
        run_op(3'b110, 8'd255, 8'd1, 1'b0, lat);
        checks++;
        if (result !== 8'hFF) begin errors++; $display("FAIL div_255_1 got %h exp ff", result); end
        run_op(3'b110, 8'd3, 8'd9, 1'b0, lat);
        checks++;
        if ({result, zero} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL div_3_9 got %h/%b exp 00/1", result, zero);
        end
        run_op(3'b110, 8'd9, 8'd0, 1'b0, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL div0_latency got %0d exp 2", lat); end
        checks++;
        if ({result, overflow, zero} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL div0_result got %h/%b/%b exp ff/1/0", result, overflow, zero);
        end
`ifdef ULA_RESTO_EN
        checks++;
        if (resto !== 8'd9) begin errors++; $display("FAIL div0_resto got %h exp 09", resto); end
`endif
    endtask

    task automatic test_ignore;
        int lat;
        logic busy_drop;
        busy_drop = 1'b0;
        @(negedge clk);
        op = 3'b101; A = 8'd12; B = 8'd11; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        op = 3'b000; A = 8'd1; B = 8'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            if (!busy) busy_drop = 1'b1;
            @(negedge clk);
            lat++;
        end
        $display("ignore: MUL 12*11 with extra start -> result=%h lat=%0d", result, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL ignore_latency got %0d exp 9", lat); end
        checks++;
        if (busy_drop !== 1'b0) begin errors++; $display("FAIL ignore_busy got drop=%b exp 0", busy_drop); end
        checks++;
        if (result !== 8'd132) begin errors++; $display("FAIL ignore_result got %h exp 84", result); end
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, result} !== {1'b0, 8'd132}) begin
            errors++; $display("FAIL ignore_no_queue got busy=%b result=%h exp 0/84", busy, result);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] res_first;
        int first_done;
        int second_done;
        logic busy_idle;
        first_done = 0; second_done = 0; res_first = '0; busy_idle = 1'b1;
        @(negedge clk);
        op = 3'b100; A = 8'h0F; B = 8'hF0; Cin = 1'b0; start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin op = 3'b011; B = 8'hFF; end
            if (n == 3) busy_idle = busy;
            if (done && first_done == 0) begin first_done = n; res_first = result; end
            else if (done && second_done == 0) second_done = n;
        end
        start = 1'b0;
        $display("back_to_back: done at %0d and %0d, results %h then %h",
                 first_done, second_done, res_first, result);
        checks++;
        if (first_done !== 2 || second_done !== 5) begin
            errors++; $display("FAIL b2b_timing got %0d,%0d exp 2,5", first_done, second_done);
        end
        checks++;
        if (busy_idle !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy_idle); end
        checks++;
        if (res_first !== 8'hFF) begin errors++; $display("FAIL b2b_first got %h exp ff", res_first); end
        repeat (4) @(negedge clk);
        checks++;
        if (result !== 8'h0F) begin errors++; $display("FAIL b2b_second got %h exp 0f", result); end
    endtask

    task automatic test_abort;
        int lat;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        op = 3'b110; A = 8'd200; B = 8'd7; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("abort: reset during DIV -> busy=%b done=%b result=%h", busy, done, result);
        checks++;
        if ({busy, done, result, overflow, zero} !== 12'h000) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b result=%h ov=%b zero=%b exp all 0",
                     busy, done, result, overflow, zero);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
        run_op(3'b100, 8'hAA, 8'hFF, 1'b0, lat);
        checks++;
        if ({result, overflow, zero} !== {8'h55, 1'b0, 1'b0}) begin
            errors++; $display("FAIL abort_xor got %h/%b/%b exp 55/0/0", result, overflow, zero);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_ignore();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
- Sequencing controller for the 8-bit ULA datapath: accepts one operation per start/done handshake and latches operands.
- Single-cycle ops (add, sub, logic, NOT) execute in one EXEC cycle; MUL uses 8-step iterative shift-add; DIV uses 8-step restoring division.
- Registers result plus overflow/zero flags, so the top level sees one registered, stable result interface instead of per-unit combinational flags.

Parameters:
- LARGURA, 8, operand/result width; iteration count for MUL/DIV equals LARGURA.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 MUL, 110 DIV, 111 NOT
- A  input  LARGURA  first operand
- B  input  LARGURA  second operand
- Cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored otherwise
- busy  output  1  high from accept edge until done pulse ends
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- result  output  LARGURA  registered result, held until next accept
- overflow  output  1  registered overflow/error flag
- zero  output  1  registered, result == 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, overflow=0, zero=0; internal operand/accumulator/counter regs cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, EXEC, MUL, DIV, FIM.
- IDLE: start=1 at edge k latches op/A/B/Cin, sets busy=1.
  - Next state: EXEC for ops 000-100 and 111; MUL for 101; DIV for 110 with B!=0; EXEC for DIV with B==0.
- EXEC, one cycle, writes result/flags at edge k+1, then FIM:
  - ADD: result = (A+B+Cin)[7:0]; overflow = carry out of bit 7.
  - SUB: result = (A-B-Cin)[7:0]; overflow = borrow (A < B+Cin, unsigned).
  - OR/AND/XOR/NOT(~A): overflow=0.
  - DIV by zero: result=8'hFF, overflow=1.
- MUL: 16-bit product accumulator, 4-bit counter; one shift-add step per cycle, 8 steps (edges k+1..k+8); result/flags written at edge k+8, then FIM. result = product[7:0]; overflow = (product[15:8] != 0).
- DIV: restoring, one quotient bit per cycle, 8 steps (edges k+1..k+8); result = quotient; overflow=0; result/flags written at edge k+8, then FIM.
- FIM: done=1 for exactly this cycle; next edge returns to IDLE, busy=0, done=0.
- Latency, start-sample edge to done high: 2 edges for EXEC ops (incl. DIV by 0); 9 edges for MUL/DIV.
- zero computed from the value written into result, same edge.
- start while busy=1 ignored; no queueing. New start accepted in the first IDLE cycle after FIM, so minimum issue interval is 3 cycles for EXEC ops.
- A/B/op changes after accept have no effect.
- result/overflow/zero hold their values until overwritten by the next completed operation.

Optional Feature:
- Macro ULA_RESTO_EN.
- Defined: extra output port resto (LARGURA), registered with result. Contents:
  - DIV: remainder.
  - MUL: product[15:8].
  - DIV by zero: A.
  - All other ops: 0.
  - Reset value 0.
- Undefined: port and its register absent; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> busy=0, done=0, result=0, overflow=0, zero=0 immediately; no done pulse follows release.
- ADD A=8'hF0, B=8'h20, Cin=1 -> done 2 edges after accept; result=8'h11, overflow=1, zero=0. SUB A=5, B=5, Cin=0 -> result=0, zero=1, overflow=0. SUB A=3, B=4 -> result=8'hFF, overflow=1.
- MUL A=8'h10, B=8'h10 -> done at 9th edge; result=8'h00, overflow=1, zero=1 (resto=8'h01 with ULA_RESTO_EN). MUL A=12, B=11 -> result=132, overflow=0.
- DIV A=200, B=7 -> result=28, overflow=0 (resto=4). DIV A=9, B=0 -> done after 2 edges; result=8'hFF, overflow=1.
- Pulse start again during a MUL with different op/A/B -> ignored; original MUL result unchanged; busy stays high until its done. Back-to-back start held high -> next op accepted on the first IDLE cycle.
- Assert rst_n=0 at DIV step 4 -> immediate return to IDLE with outputs 0; a subsequent XOR A=8'hAA, B=8'hFF -> result=8'h55.
